muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit in the execute stage, alongside the ALU. It takes the same register-file operands, a and b, that feed the ALU. It owns the architectural HI/LO registers, whose contents are selected into writeback (MFHI/MFLO) in parallel with the ALU result. A start/busy/done handshake lets the controller stall issue until the result lands in HI/LO.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default sizes.
// Pure declarations; no timing or flow-control behaviour of its own.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; gives magnitudes at capture and signed results at writeback.
// Purely combinational, zero latency, no flow control.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO; WIDTH+2 edges from start to done (divide-by-zero: 2).
// start is ignored while busy; MTHI/MTLO are honoured only when idle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             is_signed_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_signed_in = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg        = is_signed_in & a[WIDTH-1];
  assign b_neg        = is_signed_in & b[WIDTH-1];

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.din(a), .neg(a_neg), .dout(a_mag));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.din(b), .neg(b_neg), .dout(b_mag));

  // Multiply: acc_hi accumulates partial products, acc_lo shifts the multiplier out.
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  // Top bit of diff is a borrow, since the shifted remainder is always < 2*divisor.
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd};

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .din({acc_hi, acc_lo}), .neg(sign_a ^ sign_b), .dout(prod_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (
    .din(acc_lo), .neg(sign_a ^ sign_b), .dout(quot_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .din(acc_hi), .neg(sign_a), .dout(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hi) hi <= wdata;
          if (write_lo) lo <= wdata;
          if (start) begin
            is_div      <= op[1];
            sign_a      <= a_neg;
            sign_b      <= b_neg;
            cnt         <= '0;
            acc_hi      <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            acc_lo      <= op[1] ? a_mag : b_mag;
            opnd        <= op[1] ? b_mag : a_mag;
            state       <= (op[1] && (b == '0)) ? FIN : RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state <= FIN;
            done  <= 1'b1;
            if (is_div) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              if (!diff[WIDTH]) acc_hi <= diff[WIDTH-1:0];
              else              acc_hi <= shifted[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
              {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIN: begin
          // Arriving from RUN, done is already up; a divide-by-zero arrives with done low
          // and spends one extra cycle here so its done pulse lands one edge later.
          if (done) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         write_hi = 1'b0;
  logic         write_lo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference result as {HI, LO}, computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  task automatic mt_write(input bit h, input bit l, input logic [W-1:0] wd);
    @(negedge clk);
    write_hi = h;
    write_lo = l;
    wdata = wd;
    if (h) exp_hi = wd;
    if (l) exp_lo = wd;
    @(negedge clk);
    write_hi = 1'b0;
    write_lo = 1'b0;
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit mt_hi, input bit mt_lo, input logic [W-1:0] wd,
                        input bit disturb);
    int n;
    int busy_low;
    bit seen;
    bit dz;
    logic [63:0] res;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    write_hi = mt_hi; write_lo = mt_lo; wdata = wd;
    if (mt_hi) exp_hi = wd;
    if (mt_lo) exp_lo = wd;
    dz = o[1] && (y == '0);
    res = dz ? {exp_hi, exp_lo} : model(o, x, y);
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom; wdata = $urandom;
    n = 0; busy_low = 0; seen = 0;
    while (!seen && n < 100) begin
      if (!busy) busy_low++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'b11; a = 9; b = 3; write_hi = 1'b1; wdata = 32'hDEAD;
      end else begin
        start = 1'b0; write_hi = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    start = 1'b0; write_hi = 1'b0;
    check("latency", 64'(n), dz ? 64'd1 : 64'(W + 1));
    check("busy_held", 64'(busy_low), 64'd0);
    check("div_by_zero", {63'b0, div_by_zero}, {63'b0, dz});
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    @(negedge clk);
    check("done_pulse", {62'b0, busy, done}, 64'd0);
  endtask

  logic [W-1:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};

  function automatic logic [W-1:0] pick(input bit allow_zero);
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = specials[$urandom_range(0, 5)];
      1: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    if (!allow_zero && v == '0) v = 32'd7;
    return v;
  endfunction

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_dz", {63'b0, div_by_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op(2'b00, -32'sd3, 32'd7, 0, 0, 0, 0);
    run_op(2'b10, -32'sd7, 32'd2, 0, 0, 0, 0);
    mt_write(1, 0, 32'h11);
    mt_write(0, 1, 32'h22);
    run_op(2'b11, 32'd100, 32'd0, 0, 0, 0, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op(2'b01, 32'd5, 32'd6, 0, 0, 0, 1);
    mt_write(1, 1, 32'hCAFEF00D);
    run_op(2'b10, 32'd50, 32'd0, 1, 1, 32'h12345678, 0);
    run_op(2'b00, 32'd4, 32'd4, 1, 0, 32'hABCD, 0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] o;
      logic [W-1:0] x, y, wd;
      bit mh, ml;
      o = 2'($urandom_range(0, 3));
      x = pick(1);
      y = ($urandom_range(0, 7) == 0) ? '0 : pick(1);
      mh = ($urandom_range(0, 3) == 0);
      ml = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      run_op(o, x, y, mh, ml, wd, 0);
    end

    // Abort a divide part-way with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
